// File: rtl/hub75_scanner.sv
// -----------------------------------------------------------------------------
// hub75_scanner
//   Read-side consumer of the frame buffer and driver for a HUB75 LED panel.
//   Walks the displayed buffer two pixels at a time, one from the upper half
//   and one from the lower half. Each pixel is 24-bit RGB. The scanner
//   serialises binary-code-modulated bitplanes onto the panel pins and pulses
//   frame_done once per full frame.
//
//   Build option:
//     HUB75_BLANK_EN  inserts a BLANK state after every LATCH. In that state
//                     oe_n stays high for BLANK_TICKS cycles so the row
//                     drivers can settle before the plane is shown.
//
//   Ports:
//     clkb        in   sole clock, shared with the frame-buffer read port
//     resetn      in   asynchronous active-low reset
//     en          in   scan enable, sampled in IDLE and at frame end
//     addrb       out  buffer read address {row, col}
//     douta       in   upper-half pixel {R,G,B}, valid 1 cycle after addrb
//     doutb       in   lower-half pixel, same format and latency
//     r0/g0/b0    out  upper-half bit of the current plane
//     r1/g1/b1    out  lower-half bit of the current plane
//     panel_clk   out  HUB75 shift clock (clkb/4)
//     lat         out  HUB75 latch
//     oe_n        out  HUB75 output enable, active low
//     row_addr    out  HUB75 A..E row select
//     frame_done  out  one-cycle pulse after the final DISPLAY of a frame
//     busy        out  high in every state except IDLE
// -----------------------------------------------------------------------------
module hub75_scanner #(
    parameter int unsigned COLS        = 64,
    parameter int unsigned ROWS_HALF   = 32,
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned BPC         = 8,
    parameter int unsigned BASE_TICKS  = 4,
    parameter int unsigned BLANK_TICKS = 2
) (
    input  logic                         clkb,
    input  logic                         resetn,
    input  logic                         en,
    output logic [ADDR_W-1:0]            addrb,
    input  logic [23:0]                  douta,
    input  logic [23:0]                  doutb,
    output logic                         r0,
    output logic                         g0,
    output logic                         b0,
    output logic                         r1,
    output logic                         g1,
    output logic                         b1,
    output logic                         panel_clk,
    output logic                         lat,
    output logic                         oe_n,
    output logic [$clog2(ROWS_HALF)-1:0] row_addr,
    output logic                         frame_done,
    output logic                         busy
);

    localparam int unsigned COL_W   = $clog2(COLS);
    localparam int unsigned ROW_W   = $clog2(ROWS_HALF);
    localparam int unsigned PLANE_W = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int unsigned TICK_W  = $clog2(BASE_TICKS << BPC);
`ifdef HUB75_BLANK_EN
    localparam int unsigned BLANK_W = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
`endif

    // Reject parameter sets whose address split cannot match {row, col}
    if (ADDR_W != COL_W + ROW_W || BLANK_TICKS == 0) begin : g_param_check
        $error("hub75_scanner: ADDR_W must equal log2(COLS)+log2(ROWS_HALF), BLANK_TICKS must be nonzero");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_DATA,
        S_CLK,
        S_LATCH,
`ifdef HUB75_BLANK_EN
        S_BLANK,
`endif
        S_DISPLAY
    } state_t;

    // Scan state and position counters
    state_t                  r_state;
    logic [COL_W-1:0]        r_col;
    logic [ROW_W-1:0]        r_row;
    logic [PLANE_W-1:0]      r_plane;
    logic [TICK_W-1:0]       r_tick;
`ifdef HUB75_BLANK_EN
    logic [BLANK_W-1:0]      r_blank;
`endif

    // Registered panel / buffer outputs
    logic [ADDR_W-1:0]       r_addrb;
    logic [5:0]              r_rgb;
    logic                    r_panel_clk;
    logic                    r_lat;
    logic                    r_oe_n;
    logic [ROW_W-1:0]        r_row_addr;
    logic                    r_frame_done;
    logic                    r_busy;

    // Next-state values
    state_t                  w_state_nxt;
    logic [COL_W-1:0]        w_col_nxt;
    logic [ROW_W-1:0]        w_row_nxt;
    logic [PLANE_W-1:0]      w_plane_nxt;
    logic [TICK_W-1:0]       w_tick_nxt;
`ifdef HUB75_BLANK_EN
    logic [BLANK_W-1:0]      w_blank_nxt;
`endif
    logic                    w_frame_end;
    logic [ADDR_W-1:0]       w_addrb_nxt;
    logic [5:0]              w_rgb_nxt;
    logic [ROW_W-1:0]        w_row_addr_nxt;

    logic [TICK_W-1:0]       w_tick_load;
    logic [4:0]              w_bit;
    logic [5:0]              w_plane_bits;

    // Display length of the current plane minus one (down-counter preload)
    assign w_tick_load = TICK_W'((BASE_TICKS << r_plane) - 1);

    // Bit of each colour channel that belongs to the current plane
    assign w_bit        = 5'(r_plane);
    assign w_plane_bits = {douta[w_bit + 5'd16], douta[w_bit + 5'd8], douta[w_bit],
                           doutb[w_bit + 5'd16], doutb[w_bit + 5'd8], doutb[w_bit]};

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_plane_nxt = r_plane;
        w_tick_nxt  = r_tick;
`ifdef HUB75_BLANK_EN
        w_blank_nxt = r_blank;
`endif
        w_frame_end = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_state_nxt = S_ADDR;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                    w_plane_nxt = '0;
                end
            end
            S_ADDR: w_state_nxt = S_WAIT;
            S_WAIT: w_state_nxt = S_DATA;
            S_DATA: w_state_nxt = S_CLK;
            S_CLK: begin
                if (r_col == COL_W'(COLS - 1)) begin
                    w_state_nxt = S_LATCH;
                end else begin
                    w_col_nxt   = r_col + COL_W'(1);
                    w_state_nxt = S_ADDR;
                end
            end
            S_LATCH: begin
`ifdef HUB75_BLANK_EN
                w_blank_nxt = BLANK_W'(BLANK_TICKS - 1);
                w_state_nxt = S_BLANK;
`else
                w_tick_nxt  = w_tick_load;
                w_state_nxt = S_DISPLAY;
`endif
            end
`ifdef HUB75_BLANK_EN
            S_BLANK: begin
                if (r_blank == '0) begin
                    w_tick_nxt  = w_tick_load;
                    w_state_nxt = S_DISPLAY;
                end else begin
                    w_blank_nxt = r_blank - BLANK_W'(1);
                end
            end
`endif
            S_DISPLAY: begin
                if (r_tick == '0) begin
                    w_col_nxt = '0;
                    if (r_plane != PLANE_W'(BPC - 1)) begin
                        w_plane_nxt = r_plane + PLANE_W'(1);
                        w_state_nxt = S_ADDR;
                    end else begin
                        w_plane_nxt = '0;
                        if (r_row != ROW_W'(ROWS_HALF - 1)) begin
                            w_row_nxt   = r_row + ROW_W'(1);
                            w_state_nxt = S_ADDR;
                        end else begin
                            // Frame end: en is only honoured here, never mid-frame
                            w_row_nxt   = '0;
                            w_frame_end = 1'b1;
                            w_state_nxt = en ? S_ADDR : S_IDLE;
                        end
                    end
                end else begin
                    w_tick_nxt = r_tick - TICK_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Outputs are registered against the state being entered so that
        // each value is visible during the cycle of that state.
        w_addrb_nxt    = r_addrb;
        w_rgb_nxt      = r_rgb;
        w_row_addr_nxt = r_row_addr;
        case (w_state_nxt)
            S_IDLE: begin
                w_addrb_nxt    = '0;
                w_rgb_nxt      = '0;
                w_row_addr_nxt = '0;
            end
            S_ADDR:  w_addrb_nxt    = ADDR_W'({w_row_nxt, w_col_nxt});
            // douta/doutb carry the ADDR-cycle pixel during WAIT
            S_DATA:  w_rgb_nxt      = w_plane_bits;
            S_LATCH: w_row_addr_nxt = r_row;
            default: ;
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge clkb or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_plane      <= '0;
            r_tick       <= '0;
`ifdef HUB75_BLANK_EN
            r_blank      <= '0;
`endif
            r_addrb      <= '0;
            r_rgb        <= '0;
            r_panel_clk  <= 1'b0;
            r_lat        <= 1'b0;
            r_oe_n       <= 1'b1;
            r_row_addr   <= '0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_col        <= w_col_nxt;
            r_row        <= w_row_nxt;
            r_plane      <= w_plane_nxt;
            r_tick       <= w_tick_nxt;
`ifdef HUB75_BLANK_EN
            r_blank      <= w_blank_nxt;
`endif
            r_addrb      <= w_addrb_nxt;
            r_rgb        <= w_rgb_nxt;
            r_panel_clk  <= (w_state_nxt == S_CLK);
            r_lat        <= (w_state_nxt == S_LATCH);
            // Panel is lit only in DISPLAY, never while the next plane shifts
            r_oe_n       <= (w_state_nxt != S_DISPLAY);
            r_row_addr   <= w_row_addr_nxt;
            r_frame_done <= w_frame_end;
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    assign addrb      = r_addrb;
    assign r0         = r_rgb[5];
    assign g0         = r_rgb[4];
    assign b0         = r_rgb[3];
    assign r1         = r_rgb[2];
    assign g1         = r_rgb[1];
    assign b1         = r_rgb[0];
    assign panel_clk  = r_panel_clk;
    assign lat        = r_lat;
    assign oe_n       = r_oe_n;
    assign row_addr   = r_row_addr;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;

endmodule

// File: tb/tb_hub75_scanner.sv
// -----------------------------------------------------------------------------
// tb_hub75_scanner
//   Self-checking bench for hub75_scanner with COLS=4, ROWS_HALF=2, BPC=2,
//   BASE_TICKS=2, BLANK_TICKS=3. The expected pin stream for a frame is
//   generated from the row/plane/column walk and the buffer contents.
//   Honours HUB75_BLANK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_hub75_scanner;

    localparam int COLS        = 4;
    localparam int ROWS_HALF   = 2;
    localparam int ADDR_W      = 3;
    localparam int BPC         = 2;
    localparam int BASE_TICKS  = 2;
    localparam int BLANK_TICKS = 3;
    localparam int ROW_W       = 1;
`ifdef HUB75_BLANK_EN
    localparam int BLANK       = BLANK_TICKS;
`else
    localparam int BLANK       = 0;
`endif
    localparam int FRAME_CYC   = ROWS_HALF * (BPC * (4 * COLS + 1 + BLANK)
                                 + BASE_TICKS * ((1 << BPC) - 1));
    // First cycle of the second DISPLAY in a frame (row 0, plane 1)
    localparam int SECOND_DISP = (4 * COLS + 1 + BLANK + BASE_TICKS) + (4 * COLS + 1 + BLANK);

    logic                 clkb;
    logic                 resetn;
    logic                 en;
    logic [ADDR_W-1:0]    addrb;
    logic [23:0]          douta;
    logic [23:0]          doutb;
    logic                 r0, g0, b0, r1, g1, b1;
    logic                 panel_clk;
    logic                 lat;
    logic                 oe_n;
    logic [ROW_W-1:0]     row_addr;
    logic                 frame_done;
    logic                 busy;

    logic [23:0]          mem_a [0:(1<<ADDR_W)-1];
    logic [23:0]          mem_b [0:(1<<ADDR_W)-1];

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    hub75_scanner #(
        .COLS        (COLS),
        .ROWS_HALF   (ROWS_HALF),
        .ADDR_W      (ADDR_W),
        .BPC         (BPC),
        .BASE_TICKS  (BASE_TICKS),
        .BLANK_TICKS (BLANK_TICKS)
    ) dut (
        .clkb       (clkb),
        .resetn     (resetn),
        .en         (en),
        .addrb      (addrb),
        .douta      (douta),
        .doutb      (doutb),
        .r0         (r0),
        .g0         (g0),
        .b0         (b0),
        .r1         (r1),
        .g1         (g1),
        .b1         (b1),
        .panel_clk  (panel_clk),
        .lat        (lat),
        .oe_n       (oe_n),
        .row_addr   (row_addr),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clkb = 1'b0;
    always #5 clkb = ~clkb;

    // Dual read port with one cycle of latency
    always @(posedge clkb) begin
        douta <= mem_a[addrb];
        doutb <= mem_b[addrb];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (failure %0d)", tag, obs, exp, n_fail);
        end
    endtask

    function automatic logic [5:0] plane_bits(input int addr, input int p);
        logic [23:0] a;
        logic [23:0] b;
        logic [4:0]  i;
        a = mem_a[addr];
        b = mem_b[addr];
        i = 5'(p);
        return {a[i + 5'd16], a[i + 5'd8], a[i], b[i + 5'd16], b[i + 5'd8], b[i]};
    endfunction

    task automatic chk_idle_vals(input string tag, input logic fd_e);
        chk({tag, "_ctrl"}, 32'({busy, frame_done, oe_n, lat, panel_clk, row_addr}),
            32'({1'b0, fd_e, 1'b1, 1'b0, 1'b0, {ROW_W{1'b0}}}));
        chk({tag, "_addrb"}, 32'(addrb), 32'd0);
        chk({tag, "_rgb"}, 32'({r0, g0, b0, r1, g1, b1}), 32'd0);
    endtask

    task automatic expect_idle(input logic fd_e);
        @(negedge clkb);
        chk_idle_vals("idle", fd_e);
    endtask

    // One scanning cycle; addr_e/rgb_e below zero mean "not defined here"
    task automatic expect_cycle(input logic oe_e, input logic lat_e, input logic pclk_e,
                                input logic fd_e, input logic [ROW_W-1:0] ra_e,
                                input int addr_e, input int rgb_e);
        @(negedge clkb);
        chk("scan_ctrl", 32'({busy, frame_done, oe_n, lat, panel_clk, row_addr}),
            32'({1'b1, fd_e, oe_e, lat_e, pclk_e, ra_e}));
        if (addr_e >= 0) chk("scan_addrb", 32'(addrb), 32'(addr_e));
        if (rgb_e >= 0)  chk("scan_rgb", 32'({r0, g0, b0, r1, g1, b1}), 32'(rgb_e));
    endtask

    // Expected pin stream of one frame: rows, then planes, then columns
    task automatic run_frame(input bit fd_first, input logic [ROW_W-1:0] ra_init, input int drop_at);
        int               c;
        int               addr;
        logic [ROW_W-1:0] ra;
        c  = 0;
        ra = ra_init;
        for (int row = 0; row < ROWS_HALF; row++) begin
            for (int p = 0; p < BPC; p++) begin
                for (int col = 0; col < COLS; col++) begin
                    addr = row * COLS + col;
                    for (int ph = 0; ph < 4; ph++) begin
                        expect_cycle(1'b1, 1'b0, (ph == 3), (c == 0) && fd_first, ra, addr,
                                     (ph >= 2) ? int'(plane_bits(addr, p)) : -1);
                        c++;
                        if (c == drop_at) en = 1'b0;
                    end
                end
                ra = ROW_W'(row);
                expect_cycle(1'b1, 1'b1, 1'b0, 1'b0, ra, -1, -1);
                c++;
                if (c == drop_at) en = 1'b0;
                for (int b = 0; b < BLANK; b++) begin
                    expect_cycle(1'b1, 1'b0, 1'b0, 1'b0, ra, -1, -1);
                    c++;
                    if (c == drop_at) en = 1'b0;
                end
                for (int t = 0; t < (BASE_TICKS << p); t++) begin
                    expect_cycle(1'b0, 1'b0, 1'b0, 1'b0, ra, -1, -1);
                    c++;
                    if (c == drop_at) en = 1'b0;
                end
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem_a[i] = 24'($urandom);
            mem_b[i] = 24'($urandom);
        end
    endtask

    initial begin
        int t0;
        int t1;

        resetn = 1'b1;
        en     = 1'b0;
        fill_random();

        // Reset, then idle with en low
        #2 resetn = 1'b0;
        #1 chk_idle_vals("in_reset", 1'b0);
        repeat (2) @(negedge clkb);
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) expect_idle(1'b0);

        // Bit selection: upper pixel pure red, lower pixel pure blue
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem_a[i] = 24'hFF0000;
            mem_b[i] = 24'h0000FF;
        end
        en = 1'b1;
        run_frame(1'b0, '0, -1);

        // Back-to-back frames over random buffer contents
        fill_random();
        run_frame(1'b1, ROW_W'(ROWS_HALF - 1), -1);
        fill_random();
        run_frame(1'b1, ROW_W'(ROWS_HALF - 1), -1);

        // frame_done period, bounded
        t0 = -1;
        t1 = -1;
        for (int i = 0; i < 3 * FRAME_CYC && t1 < 0; i++) begin
            @(negedge clkb);
            if (frame_done) begin
                if (t0 < 0) t0 = i;
                else        t1 = i;
            end
        end
        chk("frame_period", 32'(t1 - t0), 32'(FRAME_CYC));

        // Asynchronous reset in the second DISPLAY of a frame
        repeat (SECOND_DISP + 1) @(negedge clkb);
        chk("oe_before_reset", 32'(oe_n), 32'd0);
        #2 resetn = 1'b0;
        #1 chk_idle_vals("async_reset", 1'b0);
        expect_idle(1'b0);
        expect_idle(1'b0);
        resetn = 1'b1;
        fill_random();
        run_frame(1'b0, '0, -1);

        // en dropped mid-frame: frame still completes
        fill_random();
        run_frame(1'b1, ROW_W'(ROWS_HALF - 1), 30);
        expect_idle(1'b1);
        for (int i = 0; i < 5; i++) expect_idle(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
